// File: rtl/i_mem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package i_mem_loader_pkg;

    // Instruction word returned for any address outside the loaded image.
    // i_fetch uses the same value as its reset/stall instruction.
    localparam logic [31:0] INSN_NOOP = 32'hf000_0000;

    // Width of the word address coming from i_fetch.
    localparam int ADDR_W = 20;

    // Width of one instruction word.
    localparam int DATA_W = 32;

    // LOAD: image is streaming in. RUN: image is complete and the core may fetch.
    typedef enum logic {
        LDR_LOAD = 1'b0,
        LDR_RUN  = 1'b1
    } ldr_state_e;

endpackage

// File: rtl/i_mem_loader_array.sv
// DEPTH x 32 instruction storage: one synchronous write port, one asynchronous read port.
module i_mem_loader_array
    import i_mem_loader_pkg::*;
#(
    parameter int DEPTH = 4096,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Store one image word per accepted beat; contents are never cleared.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/i_mem_loader.sv
// Instruction-memory responder for i_fetch. Loads a program image from a
// valid/ready stream, then raises fetch_en and serves zero-latency reads.
module i_mem_loader
    import i_mem_loader_pkg::*;
#(
    parameter int DEPTH = 4096
) (
    input  logic              clk,
    input  logic              rst_async,
    input  logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_read_value,
    output logic              fetch_en,
    input  logic              prog_valid,
    output logic              prog_ready,
    input  logic [DATA_W-1:0] prog_data,
    input  logic              prog_last,
    input  logic              reload,
    output logic [ADDR_W-1:0] prog_words,
    output logic              overflow
);

    localparam int IDX_W = $clog2(DEPTH);

    // Index of the final storage slot; a non-last beat here ends the load with overflow.
    localparam logic [IDX_W:0]  LAST_IDX   = (IDX_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] DEPTH_WORDS = ADDR_W'(DEPTH);

    ldr_state_e          state_q, state_d;
    logic [IDX_W:0]      wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   prog_words_q, prog_words_d;
    logic                fetch_en_q, fetch_en_d;
    logic                overflow_q, overflow_d;

    logic                beat_s;
    logic                wr_en_s;
    logic [IDX_W:0]      ptr_inc_s;
    logic [DATA_W-1:0]   arr_rd_data_s;

    assign prog_ready = (state_q == LDR_LOAD);
    assign beat_s     = prog_valid & prog_ready;
    assign ptr_inc_s  = wr_ptr_q + {{IDX_W{1'b0}}, 1'b1};

    // Next-state logic: reload has priority over any same-cycle beat.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        prog_words_d = prog_words_q;
        fetch_en_d   = fetch_en_q;
        overflow_d   = overflow_q;
        wr_en_s      = 1'b0;
        if (reload) begin
            state_d      = LDR_LOAD;
            wr_ptr_d     = '0;
            prog_words_d = '0;
            fetch_en_d   = 1'b0;
            overflow_d   = 1'b0;
        end else begin
            case (state_q)
                LDR_LOAD: begin
                    if (beat_s) begin
                        wr_en_s  = 1'b1;
                        wr_ptr_d = ptr_inc_s;
                        if (prog_last) begin
                            state_d      = LDR_RUN;
                            prog_words_d = ADDR_W'(ptr_inc_s);
                            fetch_en_d   = 1'b1;
                        end else if (wr_ptr_q == LAST_IDX) begin
                            // Storage full without a last marker: truncate the image.
                            state_d      = LDR_RUN;
                            prog_words_d = DEPTH_WORDS;
                            fetch_en_d   = 1'b1;
                            overflow_d   = 1'b1;
                        end else begin
                            state_d = LDR_LOAD;
                        end
                    end else begin
                        state_d = LDR_LOAD;
                    end
                end
                LDR_RUN: begin
                    fetch_en_d = 1'b1;
                end
                default: begin
                    state_d = LDR_LOAD;
                end
            endcase
        end
    end

    // Loader state registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            state_q      <= LDR_LOAD;
            wr_ptr_q     <= '0;
            prog_words_q <= '0;
            fetch_en_q   <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            prog_words_q <= prog_words_d;
            fetch_en_q   <= fetch_en_d;
            overflow_q   <= overflow_d;
        end
    end

    i_mem_loader_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk     (clk),
        .wr_en   (wr_en_s),
        .wr_idx  (wr_ptr_q[IDX_W-1:0]),
        .wr_data (prog_data),
        .rd_idx  (mem_address[IDX_W-1:0]),
        .rd_data (arr_rd_data_s)
    );

    // Words beyond the current image (including stale ones after reload) read as NOOP.
    assign mem_read_value = (mem_address < prog_words_q) ? arr_rd_data_s : INSN_NOOP;
    assign fetch_en       = fetch_en_q;
    assign prog_words     = prog_words_q;
    assign overflow       = overflow_q;

endmodule
